// File: rtl/fifo_pkg.sv
// Shared types for the FIFO read-port to stream adapter: buffer state encoding
// and default data width.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_e;

  // Number of words held in the output buffer for a given state.
  function automatic logic [1:0] occ_of(input buf_state_e s);
    case (s)
      ONE:     occ_of = 2'd1;
      TWO:     occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_rd_stream.sv
// Adapts a synchronous FIFO read port (1-cycle read latency) to a valid/ready
// stream via a 2-entry skid buffer. Define FIFO_RD_STREAM_CNT_EN for xfer_cnt.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]           xfer_cnt
`endif
);

  buf_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  inflight_q;
  logic                  push, pop;
  logic [2:0]            level;

  assign push = inflight_q;
  assign pop  = m_valid && m_ready;

  // Words committed after this cycle: buffered + on the FIFO bus - leaving now.
  // pop implies occ >= 1, so this never underflows.
  assign level     = {1'b0, occ_of(state_q)} + {2'b00, inflight_q} - {2'b00, pop};
  assign fifo_r_en = !rst && !fifo_empty && (level < 3'd2);

  assign m_valid = (state_q != EMPTY);
  assign m_data  = (state_q == EMPTY) ? '0 : head_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = fifo_data;
        end
      end
      ONE: begin
        case ({push, pop})
          2'b10: begin
            state_d = TWO;
            tail_d  = fifo_data;
          end
          2'b01: state_d = EMPTY;
          2'b11: head_d = fifo_data;
          default: ;
        endcase
      end
      TWO: begin
        // push is unreachable here (read gating keeps occ+inflight <= 2)
        if (pop) begin
          state_d = push ? TWO : ONE;
          head_d  = tail_q;
          if (push) tail_d = fifo_data;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      head_q     <= '0;
      tail_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= fifo_r_en;
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      xfer_cnt <= '0;
    else if (pop) xfer_cnt <= xfer_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural synchronous FIFO source.
// Counter checks are built only with FIFO_RD_STREAM_CNT_EN.
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [DW-1:0] fifo_data = '0;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0]   xfer_cnt;
`endif

  fifo_rd_stream #(.DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_r_en  (fifo_r_en),
    .fifo_data  (fifo_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .xfer_cnt   (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: data appears the cycle after an accepted read,
  // contents are flushed while rst is high.
  logic [DW-1:0] mem [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  logic          hold_empty = 1'b1;
  logic          inf_src = 1'b0;

  assign fifo_empty = inf_src ? 1'b0 : (hold_empty || (rd_ptr == wr_ptr));

  always @(posedge clk or posedge rst) begin
    if (rst) rd_ptr <= wr_ptr;
    else if (fifo_r_en) begin
      if (inf_src) fifo_data <= 8'hA5;
      else begin
        fifo_data <= mem[rd_ptr % 1024];
        rd_ptr    <= rd_ptr + 1;
      end
    end
  end

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic load(input logic [DW-1:0] v);
    mem[wr_ptr % 1024] = v;
    wr_ptr++;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    hold_empty = 1'b1;
    m_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ev;
  int            got, bad, rd_cnt, cyc;
  int            reads, pops, outst_bad;

  initial begin
    // Reset state, with the source claiming data so r_en gating by rst is seen
    rst = 1'b1; m_ready = 1'b1; inf_src = 1'b1;
    #2;
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_ren", fifo_r_en, 0);
    inf_src = 1'b0;
    do_reset();
`ifdef FIFO_RD_STREAM_CNT_EN
    chk("rst_cnt", xfer_cnt, 0);
`endif

    // Empty FIFO: no reads, no valid
    hold_empty = 1'b0; m_ready = 1'b1; bad = 0; got = 0;
    repeat (10) begin
      @(negedge clk);
      if (fifo_r_en) bad++;
      if (m_valid) got++;
    end
    chk("empty_ren", bad, 0);
    chk("empty_valid", got, 0);

    // Streaming 01..08 with m_ready high
    hold_empty = 1'b1;
    for (int i = 1; i <= 8; i++) load(i[DW-1:0]);
    @(posedge clk); #1 hold_empty = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("strm_ren%0d", c), fifo_r_en, (c < 8));
      chk($sformatf("strm_vld%0d", c), m_valid, (c >= 2 && c < 10));
      chk($sformatf("strm_dat%0d", c), m_data, (c >= 2 && c < 10) ? c - 1 : 0);
    end

    // Backpressure: 4 words, m_ready low -> 2 reads, head 01 held
    do_reset();
    for (int i = 1; i <= 4; i++) load(i[DW-1:0]);
    @(posedge clk); #1 hold_empty = 1'b0;
    rd_cnt = 0; bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_r_en) rd_cnt++;
      if (c >= 2 && (!m_valid || m_data !== 8'h01)) bad++;
    end
    chk("bp_reads", rd_cnt, 2);
    chk("bp_stable", bad, 0);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 8'h01);
    @(posedge clk); #1 m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m_valid) begin
        got++;
        chk($sformatf("bp_beat%0d", got), m_data, got);
      end
    end
    chk("bp_count", got, 4);

    // Mid-stream reset with the buffer full: outputs drop without a clock edge
    do_reset();
    for (int i = 5; i <= 8; i++) load(i[DW-1:0]);
    @(posedge clk); #1 hold_empty = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst_valid", m_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_ren", fifo_r_en, 0);
    @(posedge clk); #1 rst = 1'b0;
    hold_empty = 1'b1;

    // Random m_ready over 256 words
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 256; i++) begin
      ev = 8'(i * 7 + 3);
      load(ev);
      exp_q.push_back(ev);
    end
    @(posedge clk); #1 hold_empty = 1'b0; m_ready = 1'($urandom_range(0, 1));
    got = 0; reads = 0; pops = 0; outst_bad = 0; cyc = 0;
    while (got < 256 && cyc < 3000) begin
      @(negedge clk);
      if (reads - pops > 2) outst_bad++;
      if (fifo_r_en) reads++;
      if (m_valid && m_ready) begin
        pops++;
        got++;
        ev = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk($sformatf("rnd_beat%0d", got), m_data, ev);
      end
      cyc++;
      @(posedge clk); #1 m_ready = 1'($urandom_range(0, 1));
    end
    chk("rnd_count", got, 256);
    chk("rnd_outst", outst_bad, 0);
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1 chk("rnd_drained", m_valid, 0);
    chk("rnd_no_extra", reads, 256);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wraps: 65537 pops -> 1
    do_reset();
    inf_src = 1'b1; m_ready = 1'b1; pops = 0; cyc = 0;
    while (pops < 65537 && cyc < 70000) begin
      @(negedge clk);
      if (m_valid && m_ready) pops++;
      cyc++;
    end
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    chk("cnt_pops", pops, 65537);
    chk("cnt_wrap", xfer_cnt, 1);
    inf_src = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
